voice_allocator: RTL

- Scheduler that shares the pool of oscillator voices (pulse/saw/etc. pipelines) between incoming MIDI note events.
- Sits between the MIDI decoder and the per-voice oscillator pipelines.
- Assigns each note-on to a voice and releases voices on note-off.
- Drives per-voice note, velocity and active flags, plus a one-cycle phase-restart trigger per voice.

---
 rtl/voice_allocator.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Note-event voice allocator: scans the voice pool one voice per cycle, then claims, retriggers or
// releases a voice. Define VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice instead of dropping.
module voice_allocator #(
    parameter int unsigned NUM_VOICES     = 8,
    parameter int unsigned NOTE_WIDTH     = 7,
    parameter int unsigned VELOCITY_WIDTH = 7,
    parameter int unsigned AGE_WIDTH      = $clog2(NUM_VOICES) + 1
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 event_valid,
    output logic                                 event_ready,
    input  logic                                 event_on,
    input  logic [NOTE_WIDTH-1:0]                event_note,
    input  logic [VELOCITY_WIDTH-1:0]            event_velocity,
    output logic [NUM_VOICES-1:0]                voice_active,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0]     voice_note,
    output logic [NUM_VOICES*VELOCITY_WIDTH-1:0] voice_velocity,
    output logic [NUM_VOICES-1:0]                voice_trigger,
    output logic                                 event_dropped
);

    localparam int unsigned IDX_WIDTH = $clog2(NUM_VOICES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_VOICES - 1);
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

    state_e                    state_q, state_d;
    logic                      ev_on_q, ev_on_d;
    logic [NOTE_WIDTH-1:0]     ev_note_q, ev_note_d;
    logic [VELOCITY_WIDTH-1:0] ev_vel_q, ev_vel_d;
    logic [IDX_WIDTH-1:0]      scan_idx_q, scan_idx_d;

    logic                      match_found_q, match_found_d;
    logic [IDX_WIDTH-1:0]      match_idx_q, match_idx_d;
    logic                      free_found_q, free_found_d;
    logic [IDX_WIDTH-1:0]      free_idx_q, free_idx_d;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic                      oldest_found_q, oldest_found_d;
    logic [IDX_WIDTH-1:0]      oldest_idx_q, oldest_idx_d;
    logic [AGE_WIDTH-1:0]      oldest_age_q, oldest_age_d;
`endif

    logic [NUM_VOICES-1:0]     active_q, active_d;
    logic [NOTE_WIDTH-1:0]     note_q [NUM_VOICES];
    logic [NOTE_WIDTH-1:0]     note_d [NUM_VOICES];
    logic [VELOCITY_WIDTH-1:0] vel_q [NUM_VOICES];
    logic [VELOCITY_WIDTH-1:0] vel_d [NUM_VOICES];
    logic [AGE_WIDTH-1:0]      age_q [NUM_VOICES];
    logic [AGE_WIDTH-1:0]      age_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]     trigger_q, trigger_d;
    logic                      dropped_q, dropped_d;

    logic                      claim;
    logic [IDX_WIDTH-1:0]      claim_idx;

    assign event_ready = reset_n && (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_vel_d      = ev_vel_q;
        scan_idx_d    = scan_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
`ifdef VOICE_ALLOCATOR_STEAL_EN
        oldest_found_d = oldest_found_q;
        oldest_idx_d   = oldest_idx_q;
        oldest_age_d   = oldest_age_q;
`endif
        active_d  = active_q;
        note_d    = note_q;
        vel_d     = vel_q;
        age_d     = age_q;
        trigger_d = '0;
        dropped_d = 1'b0;
        claim     = 1'b0;
        claim_idx = '0;

        case (state_q)
            StIdle: begin
                if (event_valid && event_ready) begin
                    // Velocity 0 on a note-on is a note-off by MIDI convention.
                    ev_on_d       = event_on && (event_velocity != '0);
                    ev_note_d     = event_note;
                    ev_vel_d      = event_velocity;
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    oldest_found_d = 1'b0;
`endif
                    state_d       = StScan;
                end
            end

            StScan: begin
                if (active_q[scan_idx_q]) begin
                    if (!match_found_q && note_q[scan_idx_q] == ev_note_q) begin
                        match_found_d = 1'b1;
                        match_idx_d   = scan_idx_q;
                    end
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    // Strict compare keeps the lowest index among equal ages.
                    if (!oldest_found_q || age_q[scan_idx_q] > oldest_age_q) begin
                        oldest_found_d = 1'b1;
                        oldest_idx_d   = scan_idx_q;
                        oldest_age_d   = age_q[scan_idx_q];
                    end
`endif
                end else if (!free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d = StCommit;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_WIDTH'(1);
                end
            end

            StCommit: begin
                state_d = StIdle;
                if (ev_on_q) begin
                    if (match_found_q) begin
                        claim     = 1'b1;
                        claim_idx = match_idx_q;
                    end else if (free_found_q) begin
                        claim     = 1'b1;
                        claim_idx = free_idx_q;
                    end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                        claim     = 1'b1;
                        claim_idx = oldest_idx_q;
`else
                        dropped_d = 1'b1;
`endif
                    end
                end else if (match_found_q) begin
                    active_d[match_idx_q] = 1'b0;
                    age_d[match_idx_q]    = '0;
                end

                if (claim) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_WIDTH'(i) == claim_idx) begin
                            active_d[i]  = 1'b1;
                            note_d[i]    = ev_note_q;
                            vel_d[i]     = ev_vel_q;
                            age_d[i]     = '0;
                            trigger_d[i] = 1'b1;
                        end else if (active_q[i] && age_q[i] != AGE_MAX) begin
                            age_d[i] = age_q[i] + AGE_WIDTH'(1);
                        end
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            oldest_found_q <= 1'b0;
            oldest_idx_q   <= '0;
            oldest_age_q   <= '0;
`endif
            active_q  <= '0;
            trigger_q <= '0;
            dropped_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            ev_vel_q      <= ev_vel_d;
            scan_idx_q    <= scan_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
`ifdef VOICE_ALLOCATOR_STEAL_EN
            oldest_found_q <= oldest_found_d;
            oldest_idx_q   <= oldest_idx_d;
            oldest_age_q   <= oldest_age_d;
`endif
            active_q  <= active_d;
            trigger_q <= trigger_d;
            dropped_q <= dropped_d;
            note_q    <= note_d;
            vel_q     <= vel_d;
            age_q     <= age_d;
        end
    end

    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]             = note_q[i];
            voice_velocity[i*VELOCITY_WIDTH +: VELOCITY_WIDTH] = vel_q[i];
        end
    end

    assign voice_active  = active_q;
    assign voice_trigger = trigger_q;
    assign event_dropped = dropped_q;

endmodule
